// File: rtl/divide_unit.sv
// Multi-cycle RV32M divider: radix-2 restoring, one quotient bit per cycle.
// i_divop encoding: 3'b100 div, 3'b101 divu, 3'b110 rem, 3'b111 remu; anything else is no-op.
module divide_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic [2:0]       i_divop,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    output logic             o_stall,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] quo, rem, divisor;
    logic [CW-1:0]    counter;
    logic             sign_q, sign_r, op_rem, valid_r;
    logic             launch;

    logic             op_ok, op_signed, op_is_rem;
    logic             a_neg, b_neg, div_zero, overflow, special;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             take_sub;

    assign op_ok     = i_divop[2];
    assign op_signed = ~i_divop[0];
    assign op_is_rem = i_divop[1];
    assign a_neg     = op_signed & i_data_a[WIDTH-1];
    assign b_neg     = op_signed & i_data_b[WIDTH-1];
    assign a_mag     = a_neg ? (~i_data_a + 1'b1) : i_data_a;
    assign b_mag     = b_neg ? (~i_data_b + 1'b1) : i_data_b;
    assign div_zero  = (i_data_b == '0);
    assign overflow  = op_signed & (i_data_a == MIN_NEG) & (i_data_b == '1);
    assign special   = div_zero | overflow;

    // The partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor};
    assign take_sub  = (rem_shift >= {1'b0, divisor});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        o_stall    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start && op_ok && !i_flush) begin
                    launch     = 1'b1;
                    o_stall    = 1'b1;
                    next_state = special ? DONE : CALC;
                end
            end
            CALC: begin
                o_stall = 1'b1;
                if (counter == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (i_flush) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            counter  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            op_rem   <= 1'b0;
            valid_r  <= 1'b0;
            o_result <= '0;
        end else begin
            valid_r <= 1'b0;
            if (launch) begin
                op_rem  <= op_is_rem;
                counter <= CNT_INIT;
                divisor <= b_mag;
                // Special cases preload final values and clear the signs so DONE passes them through.
                if (div_zero) begin
                    quo    <= '1;
                    rem    <= i_data_a;
                    sign_q <= 1'b0;
                    sign_r <= 1'b0;
                end else if (overflow) begin
                    quo    <= MIN_NEG;
                    rem    <= '0;
                    sign_q <= 1'b0;
                    sign_r <= 1'b0;
                end else begin
                    quo    <= a_mag;
                    rem    <= '0;
                    sign_q <= a_neg ^ b_neg;
                    sign_r <= a_neg;
                end
            end else if (state == CALC) begin
                rem     <= take_sub ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                quo     <= {quo[WIDTH-2:0], take_sub};
                counter <= counter - 1'b1;
            end else if (state == DONE && !i_flush) begin
                if (op_rem) begin
                    o_result <= sign_r ? (~rem + 1'b1) : rem;
                end else begin
                    o_result <= sign_q ? (~quo + 1'b1) : quo;
                end
                valid_r <= 1'b1;
            end
        end
    end

    assign o_valid = valid_r & ~i_flush;

endmodule
